// File: rtl/axi4_ram_pkg.sv
// Shared encodings for the AXI4 RAM slave: burst types, response codes and FSM states.
package axi4_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; one instance per channel.
module axi4_burst_addr_gen
    import axi4_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);

    logic [1:0]            w_size;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_incr_addr;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_size      = (i_size > 3'd2) ? 2'd2 : i_size[1:0];
        w_step      = ADDR_WIDTH'(1) << w_size;
        w_incr_addr = i_addr + w_step;
        // Wrap window is (len+1) beats wide and aligned to its own size.
        w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << w_size) - ADDR_WIDTH'(1);
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
            default:     o_next_addr = w_incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_ram_slave.sv
// Word-addressed RAM behind an AXI4 slave port with independent write and read state machines.
module axi4_ram_slave
    import axi4_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_COUNT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    io_axi_aw_valid,
    output logic                    io_axi_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   io_axi_aw_payload_addr,
    input  logic [7:0]              io_axi_aw_payload_len,
    input  logic [2:0]              io_axi_aw_payload_size,
    input  logic [1:0]              io_axi_aw_payload_burst,

    input  logic                    io_axi_w_valid,
    output logic                    io_axi_w_ready,
    input  logic [DATA_WIDTH-1:0]   io_axi_w_payload_data,
    input  logic [DATA_WIDTH/8-1:0] io_axi_w_payload_strb,
    input  logic                    io_axi_w_payload_last,

    output logic                    io_axi_b_valid,
    input  logic                    io_axi_b_ready,
    output logic [1:0]              io_axi_b_payload_resp,

    input  logic                    io_axi_ar_valid,
    output logic                    io_axi_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   io_axi_ar_payload_addr,
    input  logic [7:0]              io_axi_ar_payload_len,
    input  logic [2:0]              io_axi_ar_payload_size,
    input  logic [1:0]              io_axi_ar_payload_burst,

    output logic                    io_axi_r_valid,
    input  logic                    io_axi_r_ready,
    output logic [DATA_WIDTH-1:0]   io_axi_r_payload_data,
    output logic [1:0]              io_axi_r_payload_resp,
    output logic                    io_axi_r_payload_last
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(WORD_COUNT);

    logic [DATA_WIDTH-1:0] r_mem [WORD_COUNT];

    // ---------------- write channel ----------------
    w_state_t              r_w_state, w_w_state_n;
    logic                  r_aw_ready, r_w_ready, r_b_valid;
    logic                  w_aw_ready_n, w_w_ready_n, w_b_valid_n;
    logic [ADDR_WIDTH-1:0] r_aw_addr, w_aw_next;
    logic [7:0]            r_aw_len, r_w_cnt;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;
    logic                  w_aw_fire, w_w_fire, w_b_fire;
    logic [IDX_W-1:0]      w_aw_idx;
    logic                  w_unused;

    assign w_aw_fire = io_axi_aw_valid && r_aw_ready;
    assign w_w_fire  = io_axi_w_valid  && r_w_ready;
    assign w_b_fire  = r_b_valid && io_axi_b_ready;
    assign w_aw_idx  = r_aw_addr[IDX_W+OFF_W-1:OFF_W];
    // Burst length is tracked by the beat counter; WLAST carries no control meaning here.
    assign w_unused  = io_axi_w_payload_last;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_aw_gen (
        .i_addr      (r_aw_addr),
        .i_len       (r_aw_len),
        .i_size      (r_aw_size),
        .i_burst     (r_aw_burst),
        .o_next_addr (w_aw_next)
    );

    always_comb begin
        w_w_state_n = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_fire) w_w_state_n = W_DATA;
            W_DATA:  if (w_w_fire && (r_w_cnt == r_aw_len)) w_w_state_n = W_RESP;
            W_RESP:  if (w_b_fire) w_w_state_n = W_IDLE;
            default: w_w_state_n = W_IDLE;
        endcase
        w_aw_ready_n = (w_w_state_n == W_IDLE);
        w_w_ready_n  = (w_w_state_n == W_DATA);
        w_b_valid_n  = (w_w_state_n == W_RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w_state  <= W_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
        end else begin
            r_w_state  <= w_w_state_n;
            r_aw_ready <= w_aw_ready_n;
            r_w_ready  <= w_w_ready_n;
            r_b_valid  <= w_b_valid_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_w_cnt    <= '0;
        end else if (w_aw_fire) begin
            r_aw_addr  <= io_axi_aw_payload_addr;
            r_aw_len   <= io_axi_aw_payload_len;
            r_aw_size  <= io_axi_aw_payload_size;
            r_aw_burst <= io_axi_aw_payload_burst;
            r_w_cnt    <= '0;
        end else if (w_w_fire) begin
            r_aw_addr  <= w_aw_next;
            r_w_cnt    <= r_w_cnt + 8'd1;
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM macros; contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (w_w_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (io_axi_w_payload_strb[b]) r_mem[w_aw_idx][b*8 +: 8] <= io_axi_w_payload_data[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_r_state, w_r_state_n;
    logic                  r_ar_ready, r_r_valid, r_r_last;
    logic                  w_ar_ready_n, w_r_valid_n;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic [ADDR_WIDTH-1:0] r_ar_addr, w_ar_next;
    logic [7:0]            r_ar_len, r_r_cnt;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;
    logic                  w_ar_fire, w_r_fire;
    logic [IDX_W-1:0]      w_ar_start_idx, w_ar_next_idx;

    assign w_ar_fire      = io_axi_ar_valid && r_ar_ready;
    assign w_r_fire       = r_r_valid && io_axi_r_ready;
    assign w_ar_start_idx = io_axi_ar_payload_addr[IDX_W+OFF_W-1:OFF_W];
    assign w_ar_next_idx  = w_ar_next[IDX_W+OFF_W-1:OFF_W];

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_ar_gen (
        .i_addr      (r_ar_addr),
        .i_len       (r_ar_len),
        .i_size      (r_ar_size),
        .i_burst     (r_ar_burst),
        .o_next_addr (w_ar_next)
    );

    always_comb begin
        w_r_state_n = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_fire) w_r_state_n = R_DATA;
            R_DATA:  if (w_r_fire && (r_r_cnt == r_ar_len)) w_r_state_n = R_IDLE;
            default: w_r_state_n = R_IDLE;
        endcase
        w_ar_ready_n = (w_r_state_n == R_IDLE);
        w_r_valid_n  = (w_r_state_n == R_DATA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_r_state  <= R_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
        end else begin
            r_r_state  <= w_r_state_n;
            r_ar_ready <= w_ar_ready_n;
            r_r_valid  <= w_r_valid_n;
        end
    end

    // A read in the same cycle as a write to that word sees the pre-write contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_r_cnt    <= '0;
            r_r_data   <= '0;
            r_r_last   <= 1'b0;
        end else if (w_ar_fire) begin
            r_ar_addr  <= io_axi_ar_payload_addr;
            r_ar_len   <= io_axi_ar_payload_len;
            r_ar_size  <= io_axi_ar_payload_size;
            r_ar_burst <= io_axi_ar_payload_burst;
            r_r_cnt    <= '0;
            r_r_data   <= r_mem[w_ar_start_idx];
            r_r_last   <= (io_axi_ar_payload_len == 8'd0);
        end else if (w_r_fire) begin
            if (r_r_cnt != r_ar_len) begin
                r_ar_addr <= w_ar_next;
                r_r_cnt   <= r_r_cnt + 8'd1;
                r_r_data  <= r_mem[w_ar_next_idx];
                r_r_last  <= ((r_r_cnt + 8'd1) == r_ar_len);
            end else begin
                r_r_last  <= 1'b0;
            end
        end
    end

    assign io_axi_aw_ready       = r_aw_ready;
    assign io_axi_w_ready        = r_w_ready;
    assign io_axi_b_valid        = r_b_valid;
    assign io_axi_b_payload_resp = RESP_OKAY;
    assign io_axi_ar_ready       = r_ar_ready;
    assign io_axi_r_valid        = r_r_valid;
    assign io_axi_r_payload_data = r_r_data;
    assign io_axi_r_payload_resp = RESP_OKAY;
    assign io_axi_r_payload_last = r_r_last;

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Randomized bench for axi4_ram_slave with an address-arithmetic memory model.
module tb_axi4_ram_slave;

    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    always #5 clk = ~clk;

    axi4_ram_slave dut (
        .clk                     (clk),
        .reset                   (reset),
        .io_axi_aw_valid         (aw_valid),
        .io_axi_aw_ready         (aw_ready),
        .io_axi_aw_payload_addr  (aw_addr),
        .io_axi_aw_payload_len   (aw_len),
        .io_axi_aw_payload_size  (aw_size),
        .io_axi_aw_payload_burst (aw_burst),
        .io_axi_w_valid          (w_valid),
        .io_axi_w_ready          (w_ready),
        .io_axi_w_payload_data   (w_data),
        .io_axi_w_payload_strb   (w_strb),
        .io_axi_w_payload_last   (w_last),
        .io_axi_b_valid          (b_valid),
        .io_axi_b_ready          (b_ready),
        .io_axi_b_payload_resp   (b_resp),
        .io_axi_ar_valid         (ar_valid),
        .io_axi_ar_ready         (ar_ready),
        .io_axi_ar_payload_addr  (ar_addr),
        .io_axi_ar_payload_len   (ar_len),
        .io_axi_ar_payload_size  (ar_size),
        .io_axi_ar_payload_burst (ar_burst),
        .io_axi_r_valid          (r_valid),
        .io_axi_r_ready          (r_ready),
        .io_axi_r_payload_data   (r_data),
        .io_axi_r_payload_resp   (r_resp),
        .io_axi_r_payload_last   (r_last)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [WORDS];
    logic [31:0] wbuf_data [256];
    logic [3:0]  wbuf_strb [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte address of beat i, straight from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [31:0] bytes, win, base;
        bytes = 32'd1 << ((size > 2) ? 2 : size);
        win   = 32'(len + 1) * bytes;
        base  = start - (start % win);
        if (burst == 0) return start;
        if (burst == 2) return base + ((start - base) + 32'(i) * bytes) % win;
        return start + 32'(i) * bytes;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    task automatic axi_write(input logic [31:0] addr, input int len, input int size,
                             input int burst, input int w_gaps, input int b_delay);
        int          n;
        int          wi;
        logic [31:0] wa;
        @(negedge clk);
        aw_addr  = addr;
        aw_len   = 8'(len);
        aw_size  = 3'(size);
        aw_burst = 2'(burst);
        aw_valid = 1'b1;
        n = 0;
        while (aw_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_ready_wait", 32'(aw_ready), 32'd1);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (w_gaps != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            w_valid = 1'b1;
            w_data  = wbuf_data[i];
            w_strb  = wbuf_strb[i];
            w_last  = (i == len);
            check("w_ready", 32'(w_ready), 32'd1);
            check("aw_ready_busy", 32'(aw_ready), 32'd0);
            wa = beat_addr(addr, len, size, burst, i);
            wi = widx(wa);
            for (int b = 0; b < 4; b++)
                if (wbuf_strb[i][b]) model_mem[wi][b*8 +: 8] = wbuf_data[i][b*8 +: 8];
            @(negedge clk);
            w_valid = 1'b0;
            w_last  = 1'b0;
        end
        check("b_valid", 32'(b_valid), 32'd1);
        check("b_resp", 32'(b_resp), 32'd0);
        check("w_ready_after", 32'(w_ready), 32'd0);
        repeat (b_delay) begin
            @(negedge clk);
            check("b_valid_hold", 32'(b_valid), 32'd1);
            check("aw_ready_hold", 32'(aw_ready), 32'd0);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("b_valid_done", 32'(b_valid), 32'd0);
        check("aw_ready_back", 32'(aw_ready), 32'd1);
    endtask

    // stall_mode: 0 none, 1 random 0..2 cycles per beat, 2 three cycles on beat 1.
    task automatic axi_read(input logic [31:0] addr, input int len, input int size,
                            input int burst, input int stall_mode, output logic [31:0] first_data);
        int          n;
        int          k;
        logic [31:0] exp;
        logic        exp_last;
        first_data = 32'hx;
        @(negedge clk);
        ar_addr  = addr;
        ar_len   = 8'(len);
        ar_size  = 3'(size);
        ar_burst = 2'(burst);
        ar_valid = 1'b1;
        n = 0;
        while (ar_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_ready_wait", 32'(ar_ready), 32'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            exp      = model_mem[widx(beat_addr(addr, len, size, burst, i))];
            exp_last = (i == len);
            check("r_valid", 32'(r_valid), 32'd1);
            check("r_data", r_data, exp);
            check("r_last", 32'(r_last), 32'(exp_last));
            check("r_resp", 32'(r_resp), 32'd0);
            check("ar_ready_busy", 32'(ar_ready), 32'd0);
            if (i == 0) first_data = r_data;
            k = (stall_mode == 1) ? int'($urandom_range(0, 2)) : ((stall_mode == 2 && i == 1) ? 3 : 0);
            r_ready = 1'b0;
            repeat (k) begin
                @(negedge clk);
                check("r_valid_hold", 32'(r_valid), 32'd1);
                check("r_data_hold", r_data, exp);
                check("r_last_hold", 32'(r_last), 32'(exp_last));
            end
            r_ready = 1'b1;
            @(negedge clk);
        end
        r_ready = 1'b0;
        check("r_valid_end", 32'(r_valid), 32'd0);
        check("ar_ready_end", 32'(ar_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          len, size, burst, eb;
        logic [31:0] addr;

        reset = 1'b0;
        {aw_valid, w_valid, b_ready, ar_valid, r_ready, w_last} = '0;
        {aw_addr, aw_len, aw_size, aw_burst, w_data, w_strb} = '0;
        {ar_addr, ar_len, ar_size, ar_burst} = '0;
        repeat (3) @(negedge clk);
        check("rst_aw_ready", 32'(aw_ready), 32'd0);
        check("rst_w_ready", 32'(w_ready), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_ar_ready", 32'(ar_ready), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_r_last", 32'(r_last), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_aw_ready", 32'(aw_ready), 32'd1);
        check("post_rst_ar_ready", 32'(ar_ready), 32'd1);

        // Fill the whole array with four maximum-length INCR bursts.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf_data[i] = $urandom;
                wbuf_strb[i] = 4'hF;
            end
            axi_write(32'(blk * 1024), 255, 2, 1, 0, 0);
        end
        axi_read(32'd0, 255, 2, 1, 0, d);

        wbuf_data[0] = 32'hDEADBEEF;
        wbuf_strb[0] = 4'hF;
        axi_write(32'h10, 0, 2, 1, 0, 0);
        axi_read(32'h10, 0, 2, 1, 0, d);
        check("single_read", d, 32'hDEADBEEF);
        axi_read(32'h1010, 0, 2, 1, 0, d);
        check("alias_read", d, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) begin
            wbuf_data[i] = 32'(i + 1);
            wbuf_strb[i] = 4'hF;
        end
        axi_write(32'h100, 3, 2, 1, 0, 3);
        axi_read(32'h100, 3, 2, 1, 2, d);
        check("incr4_first", d, 32'd1);

        for (int i = 0; i < 4; i++) begin
            wbuf_data[i] = 32'hA0 + 32'(i);
            wbuf_strb[i] = 4'hF;
        end
        axi_write(32'h200, 3, 2, 1, 0, 0);
        axi_read(32'h208, 3, 2, 2, 0, d);
        check("wrap_first", d, 32'hA2);

        wbuf_data[0] = 32'hFFFFFFFF;
        wbuf_strb[0] = 4'hF;
        axi_write(32'h0, 0, 2, 1, 0, 0);
        wbuf_data[0] = 32'h11223344;
        wbuf_strb[0] = 4'b0101;
        axi_write(32'h0, 0, 2, 1, 0, 0);
        axi_read(32'h0, 0, 2, 1, 0, d);
        check("strobe_merge", d, 32'hFF22FF44);

        // Reset after two beats of a four-beat write.
        @(negedge clk);
        aw_addr = 32'h300; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'd1; aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_valid = 1'b1;
            w_data  = 32'hC0DE0000 + 32'(i);
            w_strb  = 4'hF;
            model_mem[widx(32'h300 + 32'(4 * i))] = w_data;
            @(negedge clk);
        end
        w_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("abort_aw_ready", 32'(aw_ready), 32'd0);
        check("abort_w_ready", 32'(w_ready), 32'd0);
        check("abort_b_valid", 32'(b_valid), 32'd0);
        check("abort_ar_ready", 32'(ar_ready), 32'd0);
        check("abort_r_valid", 32'(r_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rel_aw_ready", 32'(aw_ready), 32'd1);
        check("abort_rel_ar_ready", 32'(ar_ready), 32'd1);
        check("abort_rel_b_valid", 32'(b_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wbuf_data[i] = $urandom;
            wbuf_strb[i] = 4'hF;
        end
        axi_write(32'h300, 3, 2, 1, 0, 0);
        axi_read(32'h300, 3, 2, 1, 0, d);
        check("after_abort_read", d, wbuf_data[0]);

        // Randomized traffic, including reserved burst and oversize encodings.
        for (int t = 0; t < 30; t++) begin
            burst = int'($urandom_range(0, 3));
            size  = int'($urandom_range(0, 3));
            eb    = 1 << ((size > 2) ? 2 : size);
            len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : int'($urandom_range(0, 20));
            addr  = $urandom & ~32'(eb - 1);
            for (int i = 0; i <= len; i++) begin
                wbuf_data[i] = $urandom;
                wbuf_strb[i] = 4'($urandom);
            end
            axi_write(addr, len, size, burst, 1, int'($urandom_range(0, 2)));

            burst = int'($urandom_range(0, 3));
            size  = int'($urandom_range(0, 3));
            eb    = 1 << ((size > 2) ? 2 : size);
            len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : int'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(eb - 1);
            else                           addr = $urandom & ~32'(eb - 1);
            axi_read(addr, len, size, burst, 1, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
